// File: rtl/imem_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// imem_fetch_ctrl
//   Fetch sequencer for a byte-wide instruction memory with 1-cycle read
//   latency. Holds the PC, issues four byte reads per instruction, assembles
//   them little-endian into a 32-bit word and hands the word to decode over
//   a valid/ready handshake. Redirects from execute restart the fetch.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | not fetching; waits for fetch_en
//   FETCH | issuing byte reads pc+0..pc+3 (cnt selects the byte)
//   WAIT  | no read; final byte of the word lands this cycle
//   HOLD  | instr_valid=1, word held until the consumer takes it
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   fetch_en                   allow fetching (sampled in IDLE / on handshake)
//   mem_rd_en, mem_addr        byte read request to instruction memory
//   mem_rdata                  read byte, valid the cycle after mem_rd_en
//   instr, instr_pc            assembled word and its PC
//   instr_valid, instr_ready   delivery handshake to decode
//   redirect_valid/_pc         restart fetch at a new PC (highest priority)
//   misaligned_err             pulse: last redirect PC had nonzero [1:0]
//   fetch_busy                 state is not IDLE
// ---------------------------------------------------------------------------
module imem_fetch_ctrl #(
  parameter int          ADDR_W   = 5,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              misaligned_err,
  output logic              fetch_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic        rd_pend_q, rd_pend_d;
  logic [1:0]  rd_idx_q, rd_idx_d;
  logic [31:0] instr_q;
  logic        mis_q, mis_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 2'd0;
      pc_q      <= RESET_PC;
      rd_pend_q <= 1'b0;
      rd_idx_q  <= 2'd0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_q      <= pc_d;
      rd_pend_q <= rd_pend_d;
      rd_idx_q  <= rd_idx_d;
      mis_q     <= mis_d;
    end
  end

  // Byte lanes are written as their reads return; lanes not yet refreshed
  // keep the previous word, which is harmless because instr is only
  // qualified by instr_valid after all four lanes have landed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= 32'h0;
    end else if (rd_pend_q) begin
      case (rd_idx_q)
        2'd0:    instr_q[7:0]   <= mem_rdata;
        2'd1:    instr_q[15:8]  <= mem_rdata;
        2'd2:    instr_q[23:16] <= mem_rdata;
        default: instr_q[31:24] <= mem_rdata;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_d        = pc_q;
    mis_d       = 1'b0;
    mem_rd_en   = 1'b0;
    mem_addr    = '0;
    instr_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (fetch_en) begin
          state_d = S_FETCH;
          cnt_d   = 2'd0;
        end
      end
      S_FETCH: begin
        mem_rd_en = 1'b1;
        // Address wraps within the memory; the PC itself stays 32-bit.
        mem_addr  = pc_q[ADDR_W-1:0] + ADDR_W'(cnt_q);
        cnt_d     = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = S_WAIT;
      end
      S_WAIT: begin
        state_d = S_HOLD;
      end
      default: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          pc_d    = pc_q + 32'd4;
          cnt_d   = 2'd0;
          state_d = fetch_en ? S_FETCH : S_IDLE;
        end
      end
    endcase

    rd_pend_d = mem_rd_en;
    rd_idx_d  = cnt_q;

    // Redirect overrides everything; clearing rd_pend drops the byte read
    // this cycle so it cannot pollute the new word.
    if (redirect_valid) begin
      state_d   = S_FETCH;
      cnt_d     = 2'd0;
      pc_d      = {redirect_pc[31:2], 2'b00};
      rd_pend_d = 1'b0;
      mis_d     = |redirect_pc[1:0];
    end
  end

  assign instr          = instr_q;
  assign instr_pc       = pc_q;
  assign misaligned_err = mis_q;
  assign fetch_busy     = (state_q != S_IDLE);

endmodule
